switch_ingress_buffer: RTL and testbench

- Per-port store-and-forward ingress buffer between a port's input stream and the 4-port switch crossbar/arbiter; one instance per port.
- Accepts byte-wide framed packets and stores whole packets only.
- Presents a packet to the crossbar only after its last byte has been committed, with the decoded destination mask held for the whole packet.
- Drops malformed, oversized, loopback-only and overflowing packets, and counts them.

---
 rtl/switch_ingress_buffer.sv | 214 +++++++++++++++++++++
 tb/tb_switch_ingress_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/switch_ingress_buffer.sv
// switch_ingress_buffer
//   Per-port store-and-forward ingress buffer feeding the 4-port crossbar.
//   Whole packets are written speculatively and published to the read side
//   only on their last byte. Malformed, oversized, loopback-only and
//   overflowing packets are dropped and counted. There is no backpressure.
// Ports
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_sop/in_eop/in_data      byte stream in (header: [3:0] dest, [7:4] src)
//   in_ready                            1 out of reset
//   out_valid/out_ready/out_sop/out_eop/out_data  registered show-ahead byte stream out
//   out_dest                            effective destination of head packet
//   pkt_cnt, drop_cnt                   saturating packet counters
//   level                               occupied entries, uncommitted included
module switch_ingress_buffer #(
    parameter int DEPTH   = 64,
    parameter int MAX_LEN = 16,
    parameter int PORT_ID = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_sop,
    input  logic                     in_eop,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [7:0]               out_data,
    output logic [3:0]               out_dest,
    output logic [15:0]              pkt_cnt,
    output logic [15:0]              drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SD  = DEPTH / 2;
    localparam int SAW = $clog2(SD);
    localparam int LW  = $clog2(MAX_LEN + 1);
    localparam logic [AW:0]   DEPTH_P = (AW+1)'(DEPTH);
    localparam logic [SAW:0]  SD_P    = (SAW+1)'(SD);
    localparam logic [LW-1:0] MAX_P   = LW'(MAX_LEN);
    localparam logic [3:0]    LB_MASK = 4'(1 << PORT_ID);

    typedef enum logic [1:0] {S_IDLE, S_STORE, S_DROP} state_t;

    logic [9:0] mem [DEPTH];
    logic [3:0] side_mem [SD];

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, wr_cmt_q, wr_cmt_d, rd_ptr_q, rd_ptr_d;
    logic [SAW:0]  swr_q, swr_d, srd_q, srd_d;
    logic [LW-1:0] len_q, len_d;
    logic [3:0]    eff_q, eff_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;
    logic          in_ready_q;
    logic          out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
    logic [7:0]    out_data_q, out_data_d;
    logic [3:0]    out_dest_q, out_dest_d;

    logic          we, push, pkt_inc, start, full, cmt_full, side_full, xfer;
    logic [AW-1:0] waddr;
    logic [9:0]    wdata, rd_entry;
    logic [3:0]    push_val, eff_in;
    logic [1:0]    drop_n;
    logic [16:0]   drop_sum;

    // full uses the pre-read level; after a rewind only committed data counts
    assign full      = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    assign cmt_full  = (wr_cmt_q - rd_ptr_q) == DEPTH_P;
    assign side_full = (swr_q - srd_q) == SD_P;
    assign eff_in    = in_data[3:0] & ~LB_MASK;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        wr_cmt_d = wr_cmt_q;
        len_d    = len_q;
        eff_d    = eff_q;
        we       = 1'b0;
        waddr    = wr_ptr_q[AW-1:0];
        wdata    = {in_sop, in_eop, in_data};
        push     = 1'b0;
        push_val = eff_q;
        pkt_inc  = 1'b0;
        drop_n   = 2'd0;
        start    = 1'b0;
        if (in_valid) begin
            case (state_q)
                S_STORE: begin
                    if (in_sop) begin
                        // missing eop: discard partial, restart on this header
                        wr_ptr_d = wr_cmt_q;
                        drop_n   = 2'd1;
                        start    = 1'b1;
                    end else if (full || len_q == MAX_P || side_full) begin
                        wr_ptr_d = wr_cmt_q;
                        drop_n   = 2'd1;
                        state_d  = in_eop ? S_IDLE : S_DROP;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        len_d    = len_q + LW'(1);
                        if (in_eop) begin
                            wr_cmt_d = wr_ptr_q + 1'b1;
                            push     = 1'b1;
                            pkt_inc  = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end
                end
                default: begin
                    if (in_sop)
                        start = 1'b1;
                    else if (state_q == S_DROP && in_eop)
                        state_d = S_IDLE;
                end
            endcase
            // header handling; wr_cmt_q is the write base in every start case
            if (start) begin
                if (eff_in == 4'd0 || cmt_full || side_full) begin
                    drop_n  = drop_n + 2'd1;
                    state_d = in_eop ? S_IDLE : S_DROP;
                end else begin
                    we       = 1'b1;
                    waddr    = wr_cmt_q[AW-1:0];
                    wr_ptr_d = wr_cmt_q + 1'b1;
                    len_d    = LW'(1);
                    eff_d    = eff_in;
                    if (in_eop) begin
                        wr_cmt_d = wr_cmt_q + 1'b1;
                        push     = 1'b1;
                        push_val = eff_in;
                        pkt_inc  = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_STORE;
                    end
                end
            end
        end
        swr_d = push ? swr_q + 1'b1 : swr_q;

        pkt_cnt_d  = (pkt_inc && pkt_cnt_q != 16'hFFFF) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
        drop_sum   = {1'b0, drop_cnt_q} + {15'd0, drop_n};
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // read side: output regs always mirror the entry at the next head pointer
    always_comb begin
        xfer        = out_valid_q & out_ready;
        rd_ptr_d    = xfer ? rd_ptr_q + 1'b1 : rd_ptr_q;
        srd_d       = (xfer && out_eop_q) ? srd_q + 1'b1 : srd_q;
        rd_entry    = mem[rd_ptr_d[AW-1:0]];
        out_valid_d = (wr_cmt_q != rd_ptr_d);
        out_sop_d   = out_valid_d & rd_entry[9];
        out_eop_d   = out_valid_d & rd_entry[8];
        out_data_d  = out_valid_d ? rd_entry[7:0] : 8'd0;
        out_dest_d  = out_valid_d ? side_mem[srd_d[SAW-1:0]] : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (we)   mem[waddr] <= wdata;
        if (push) side_mem[swr_q[SAW-1:0]] <= push_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            wr_cmt_q    <= '0;
            rd_ptr_q    <= '0;
            swr_q       <= '0;
            srd_q       <= '0;
            len_q       <= '0;
            eff_q       <= '0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_data_q  <= '0;
            out_dest_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_cmt_q    <= wr_cmt_d;
            rd_ptr_q    <= rd_ptr_d;
            swr_q       <= swr_d;
            srd_q       <= srd_d;
            len_q       <= len_d;
            eff_q       <= eff_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            in_ready_q  <= 1'b1;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_data_q  <= out_data_d;
            out_dest_q  <= out_dest_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_data  = out_data_q;
    assign out_dest  = out_dest_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign level     = wr_ptr_q - rd_ptr_q;
endmodule

// File: tb/tb_switch_ingress_buffer.sv
module tb_switch_ingress_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vld = 1'b0, sop = 1'b0, eop = 1'b0;
    logic [7:0] data = 8'd0;
    logic rdy0 = 1'b1, rdy2 = 1'b1;
    int   sel = 0;

    always #5 clk = ~clk;

    // d0: DEPTH 16, port 0   d2: DEPTH 64, port 2
    logic irdy0, ov0, os0, oe0, irdy2, ov2, os2, oe2;
    logic [7:0] odat0, odat2;
    logic [3:0] od0, od2;
    logic [15:0] pc0, dc0, pc2, dc2;
    logic [4:0] lv0;
    logic [6:0] lv2;

    switch_ingress_buffer #(.DEPTH(16), .MAX_LEN(16), .PORT_ID(0)) d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld && sel == 0), .in_sop(sop), .in_eop(eop),
        .in_data(data), .in_ready(irdy0), .out_valid(ov0), .out_ready(rdy0), .out_sop(os0),
        .out_eop(oe0), .out_data(odat0), .out_dest(od0), .pkt_cnt(pc0), .drop_cnt(dc0), .level(lv0));

    switch_ingress_buffer #(.DEPTH(64), .MAX_LEN(16), .PORT_ID(2)) d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld && sel == 2), .in_sop(sop), .in_eop(eop),
        .in_data(data), .in_ready(irdy2), .out_valid(ov2), .out_ready(rdy2), .out_sop(os2),
        .out_eop(oe2), .out_data(odat2), .out_dest(od2), .pkt_cnt(pc2), .drop_cnt(dc2), .level(lv2));

    // transferred beats {dest, sop, eop, data} of the selected instance
    logic [13:0] q[$];
    bit seen = 1'b0;
    always @(negedge clk) begin
        if (sel == 0) begin
            if (ov0 && rdy0) q.push_back({od0, os0, oe0, odat0});
            if (ov0) seen = 1'b1;
        end else begin
            if (ov2 && rdy2) q.push_back({od2, os2, oe2, odat2});
            if (ov2) seen = 1'b1;
        end
    end

    int nvec = 0, nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pbyte(input logic [7:0] hdr, input int k);
        return (k == 0) ? hdr : 8'(8'hA0 + k);
    endfunction

    // called at posedge+1; returns at posedge+1 after the last beat
    task automatic send_pkt(input logic [7:0] hdr, input int n, input bit with_eop);
        for (int k = 0; k < n; k++) begin
            vld = 1'b1; sop = (k == 0); eop = with_eop && (k == n - 1); data = pbyte(hdr, k);
            @(posedge clk); #1;
        end
        vld = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic expect_pkt(input string tag, input int idx, input logic [7:0] hdr,
                              input int n, input logic [3:0] dest);
        logic [13:0] got, exp;
        for (int k = 0; k < n; k++) begin
            got = (idx + k < q.size()) ? q[idx + k] : 14'h3FFF;
            exp = {dest, k == 0, k == n - 1, pbyte(hdr, k)};
            chk($sformatf("%s_b%0d", tag, k), 32'(got), 32'(exp));
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_in_ready", irdy0, 0);
        chk("rst_out_valid", ov0, 0);
        chk("rst_pkt_cnt", pc0, 0);
        chk("rst_drop_cnt", dc0, 0);
        chk("rst_level", lv0, 0);
        @(negedge clk) rst_n = 1'b1;
        cyc(1);
        chk("in_ready_up", irdy0, 1);

        // basic packet and latency
        send_pkt(8'h14, 5, 1);
        chk("t1_lat_early", ov0, 0);
        cyc(1);
        chk("t1_lat_valid", ov0, 1);
        chk("t1_lat_sop", os0, 1);
        chk("t1_lat_dest", od0, 4'h4);
        cyc(6);
        chk("t1_nbeats", q.size(), 5);
        expect_pkt("t1", 0, 8'h14, 5, 4'h4);
        chk("t1_pkt_cnt", pc0, 1);
        chk("t1_level", lv0, 0);

        // oversize then a good packet
        q.delete();
        send_pkt(8'h12, 17, 1);
        cyc(3);
        chk("ovs_drop_cnt", dc0, 1);
        chk("ovs_level", lv0, 0);
        chk("ovs_nbeats", q.size(), 0);
        send_pkt(8'h18, 3, 1);
        cyc(6);
        expect_pkt("ovs_next", 0, 8'h18, 3, 4'h8);
        chk("ovs_pkt_cnt", pc0, 2);

        // missing eop
        q.delete();
        send_pkt(8'h12, 4, 0);
        send_pkt(8'h14, 4, 1);
        cyc(8);
        chk("meop_nbeats", q.size(), 4);
        expect_pkt("meop", 0, 8'h14, 4, 4'h4);
        chk("meop_drop_cnt", dc0, 2);
        chk("meop_pkt_cnt", pc0, 3);

        // overflow with output stalled
        rdy0 = 1'b0;
        q.delete();
        send_pkt(8'h22, 8, 1);
        send_pkt(8'h34, 8, 1);
        send_pkt(8'h18, 4, 1);
        cyc(2);
        chk("ovf_level", lv0, 16);
        chk("ovf_drop_cnt", dc0, 3);
        chk("ovf_pkt_cnt", pc0, 5);
        chk("ovf_valid", ov0, 1);
        rdy0 = 1'b1;
        cyc(16);
        chk("ovf_rate_nbeats", q.size(), 16);
        chk("ovf_drained", ov0, 0);
        chk("ovf_level_end", lv0, 0);
        expect_pkt("ovf_p0", 0, 8'h22, 8, 4'h2);
        expect_pkt("ovf_p1", 8, 8'h34, 8, 4'h4);

        // loopback on port 2
        sel = 2;
        q.delete();
        seen = 1'b0;
        send_pkt(8'h04, 3, 1);
        cyc(4);
        chk("lb_seen", seen, 0);
        chk("lb_drop_cnt", dc2, 1);
        chk("lb_pkt_cnt", pc2, 0);
        send_pkt(8'h06, 3, 1);
        cyc(6);
        chk("lb_nbeats", q.size(), 3);
        expect_pkt("lb_ok", 0, 8'h06, 3, 4'h2);

        // async reset mid-read
        sel = 0;
        rdy0 = 1'b0;
        q.delete();
        send_pkt(8'h12, 10, 1);
        cyc(2);
        rdy0 = 1'b1;
        cyc(3);
        chk("ar_midread", ov0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", ov0, 0);
        chk("ar_sop", os0, 0);
        chk("ar_data", odat0, 0);
        chk("ar_dest", od0, 0);
        chk("ar_pkt_cnt", pc0, 0);
        chk("ar_drop_cnt", dc0, 0);
        chk("ar_level", lv0, 0);
        chk("ar_in_ready", irdy0, 0);
        @(negedge clk) rst_n = 1'b1;
        cyc(1);
        chk("ar_in_ready_up", irdy0, 1);
        chk("ar_no_glitch", ov0, 0);
        q.delete();
        send_pkt(8'h18, 3, 1);
        cyc(6);
        chk("ar_nbeats", q.size(), 3);
        expect_pkt("ar_next", 0, 8'h18, 3, 4'h8);
        chk("ar_pkt_cnt_end", pc0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
